e_nested_split: RTL and testbench
=================================

# e_nested_split

Receive-side splitter for the `eNestedSt` record.
- Accepts one nested record over a valid/ready handshake.
- Emits its `dSt` field, then both `seeSt` elements, as separate single-beat transfers on two downstream channels.
- Sits on the consumer end of the path that assembles `eNestedSt` from `dSt` and `seeSt` pieces; it is the inverse of that packer.
- Reports readiness as `readyT` and keeps a count of completed records.

## Interface
Parameters:
- `CNT_W`, default 8: width of the completed-record counter.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high; asserted = reset.
- `in_valid`  in  1  input record valid.
- `in_ready`  out  1  block can accept a record this cycle.
- `in_data`  in  18  `eNestedSt` (`variablea`, `bob`, `joe[1:0]`).
- `d_valid`  out  1  `dSt` beat valid.
- `d_ready`  in  1  downstream accepts the `dSt` beat.
- `d_data`  out  7  `dSt`.
- `c_valid`  out  1  `seeSt` beat valid.
- `c_ready`  in  1  downstream accepts the `seeSt` beat.
- `c_data`  out  5  `seeSt`.
- `c_index`  out  1  index of `joe` element currently on `c_data`.
- `status`  out  1  `readyT`: `READY_YES` when `in_ready` is 1, else `READY_NO`.
- `done_count`  out  CNT_W  records fully emitted, modulo 2^CNT_W.

## Operation
- One holding register of 18 bits plus a state machine with four states: `IDLE`, `SEND_D`, `SEND_C0`, `SEND_C1`.
- `IDLE`:
  - `in_ready`=1.
  - On `in_valid&&in_ready`: capture `in_data`, go to `SEND_D`.
- `SEND_D`:
  - `d_valid`=1, `d_data`=held `bob`.
  - On `d_ready`: go to `SEND_C0`.
- `SEND_C0`:
  - `c_valid`=1.
  - Element order is set by held `variablea`:
    - `variablea`=0: `c_index`=0, `c_data`=`joe[0]`.
    - `variablea`=1: `c_index`=1, `c_data`=`joe[1]`.
  - On `c_ready`: go to `SEND_C1`.
- `SEND_C1`:
  - `c_valid`=1, carrying the other `joe` element and its index.
  - On `c_ready`: increment `done_count`, and set `in_ready`=1 combinationally in this cycle.
  - If `in_valid` is also 1: capture the new record and go to `SEND_D` (back-to-back). Otherwise go to `IDLE`.
- Validity and data stability:
  - `d_valid` and `c_valid` are never both 1.
  - `d_data`, `c_data` and `c_index` are driven from registers. They hold their value while the matching valid is 1 and ready is 0.
  - `d_data`, `c_data` and `c_index` are don't-care when the matching valid is 0; the bench does not check them then.
- `in_ready`=0 in `SEND_D` and `SEND_C0`, and in `SEND_C1` unless `c_ready`=1. Input is never dropped or overwritten while held.
- `done_count` wraps from 2^CNT_W−1 to 0 with no flag.
- `in_data` is not checked for X or range. `variablea` is only the order bit.

## Timing
- Reset values: state=`IDLE`, `in_ready`=1, `status`=`READY_YES`, `d_valid`=0, `c_valid`=0, `d_data`=0, `c_data`=0, `c_index`=0, `done_count`=0, holding register=0.
- Reset asserted mid-record: the in-flight record is discarded. No partial beat appears after reset is released.
- Latency: input accepted at edge N → `d_valid` at N+1.
- No backpressure: beats at N+1, N+2, N+3. Next record is accepted at N+3, giving a sustained 3 cycles per record.
- Downstream stalls add cycles one-for-one in the stalled state only.
- `done_count` updates at the edge that completes the second `c` beat and is visible the following cycle.
- `in_ready` and `status` are the only combinational outputs. They depend only on `c_ready` and state. There is no path from `in_valid` to any output.

## Structure
- Shared package:
  - `eNestedSt`, `dSt`, `seeSt`, `readyT`.
  - A new enum `splitStateT` (2 bits) for the four states.
  - A constant `JOE_CNT` = 2, the `joe` array length.
- Single module; no sub-module needed.
- The element-select mux is a plain function of state and `variablea` inside the module.

## Test plan
- Basic flow: one record with `variablea`=0, `bob`=7'h5A, `joe[0]`=5'h03, `joe[1]`=5'h1C, both readys held at 1.
  - Expect d=7'h5A at N+1, c=5'h03 with index 0 at N+2, c=5'h1C with index 1 at N+3, `done_count`=1.
- Order reversal: same record with `variablea`=1.
  - Expect c=5'h1C with index 1 first, then c=5'h03 with index 0.
- Backpressure: hold `d_ready`=0 for 4 cycles, then `c_ready`=0 for 3 cycles on the second beat.
  - Expect `d_data`/`c_data` stable throughout, `in_ready`=0, and the record completes after exactly 7 extra cycles.
- Back-to-back: `in_valid` held at 1 across 5 records with readys at 1.
  - Expect accepts every 3 cycles, 15 beats in order, `done_count`=5.
- Reset mid-record: assert `rst` during `SEND_C0`.
  - Expect all outputs at reset values immediately, no `c` beat after release, `done_count`=0, next record processed normally.
- Wrap: with `CNT_W`=2, send 5 records.
  - Expect `done_count` sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/e_nested_split_pkg.sv
// Shared types for the eNestedSt receive-side splitter: record layout,
// beat payloads, readiness flag and splitter FSM encoding.
package e_nested_split_pkg;

  localparam int JOE_CNT = 2;

  typedef logic [6:0] dSt;
  typedef logic [4:0] seeSt;

  // variablea sits in the MSB, joe[0] in the LSBs.
  typedef struct packed {
    logic                 variablea;
    dSt                   bob;
    seeSt [JOE_CNT-1:0]   joe;
  } eNestedSt;

  typedef enum logic {
    READY_NO  = 1'b0,
    READY_YES = 1'b1
  } readyT;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_D  = 2'd1,
    SEND_C0 = 2'd2,
    SEND_C1 = 2'd3
  } splitStateT;

endpackage

// File: rtl/e_nested_split_if.sv
// Record-in / beat-out bundle for the splitter. master is the surrounding
// system (producer plus both consumers), slave is the splitter itself.
interface e_nested_split_if #(
  parameter int CNT_W = 8
);
  import e_nested_split_pkg::*;

  logic             in_valid;
  logic             in_ready;
  eNestedSt         in_data;
  logic             d_valid;
  logic             d_ready;
  dSt               d_data;
  logic             c_valid;
  logic             c_ready;
  seeSt             c_data;
  logic             c_index;
  readyT            status;
  logic [CNT_W-1:0] done_count;

  modport master (
    output in_valid, in_data, d_ready, c_ready,
    input  in_ready, d_valid, d_data, c_valid, c_data, c_index, status, done_count
  );

  modport slave (
    input  in_valid, in_data, d_ready, c_ready,
    output in_ready, d_valid, d_data, c_valid, c_data, c_index, status, done_count
  );

endinterface

// File: rtl/e_nested_split.sv
// Splits one eNestedSt record into a dSt beat followed by two seeSt beats;
// variablea picks which joe element goes first.
module e_nested_split
  import e_nested_split_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  e_nested_split_if.slave bus
);

  splitStateT       state_q, state_d;
  eNestedSt         hold_q, hold_d;
  dSt               d_data_q, d_data_d;
  seeSt             c_data_q, c_data_d;
  logic             c_index_q, c_index_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready;

  // joe element carried in a given c state: variablea first, its complement second.
  function automatic logic elem_idx(splitStateT st, logic va);
    return (st == SEND_C1) ? ~va : va;
  endfunction

  assign in_ready = (state_q == IDLE) || (state_q == SEND_C1 && bus.c_ready);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    d_data_d  = d_data_q;
    c_data_d  = c_data_q;
    c_index_d = c_index_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          hold_d   = bus.in_data;
          d_data_d = bus.in_data.bob;
          state_d  = SEND_D;
        end
      end
      SEND_D: begin
        if (bus.d_ready) begin
          c_index_d = elem_idx(SEND_C0, hold_q.variablea);
          c_data_d  = hold_q.joe[elem_idx(SEND_C0, hold_q.variablea)];
          state_d   = SEND_C0;
        end
      end
      SEND_C0: begin
        if (bus.c_ready) begin
          c_index_d = elem_idx(SEND_C1, hold_q.variablea);
          c_data_d  = hold_q.joe[elem_idx(SEND_C1, hold_q.variablea)];
          state_d   = SEND_C1;
        end
      end
      SEND_C1: begin
        if (bus.c_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.in_valid) begin
            hold_d   = bus.in_data;
            d_data_d = bus.in_data.bob;
            state_d  = SEND_D;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      d_data_q  <= '0;
      c_data_q  <= '0;
      c_index_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      d_data_q  <= d_data_d;
      c_data_q  <= c_data_d;
      c_index_q <= c_index_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.status     = in_ready ? READY_YES : READY_NO;
  assign bus.d_valid    = (state_q == SEND_D);
  assign bus.c_valid    = (state_q == SEND_C0) || (state_q == SEND_C1);
  assign bus.d_data     = d_data_q;
  assign bus.c_data     = c_data_q;
  assign bus.c_index    = c_index_q;
  assign bus.done_count = cnt_q;

endmodule

// File: tb/tb_e_nested_split.sv
// Directed bench for e_nested_split: a CNT_W=8 instance driven by the tasks
// and a CNT_W=2 shadow instance fed the same inputs for the wrap check.
module tb_e_nested_split;
  import e_nested_split_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  e_nested_split_if #(.CNT_W(8)) bf ();
  e_nested_split_if #(.CNT_W(2)) bw ();

  e_nested_split #(.CNT_W(8)) dut   (.clk(clk), .rst(rst), .bus(bf));
  e_nested_split #(.CNT_W(2)) dut_w (.clk(clk), .rst(rst), .bus(bw));

  assign bw.in_valid = bf.in_valid;
  assign bw.in_data  = bf.in_data;
  assign bw.d_ready  = bf.d_ready;
  assign bw.c_ready  = bf.c_ready;

  typedef struct {
    int         cyc;
    bit         is_c;
    logic [6:0] data;
    logic       idx;
  } beat_t;

  beat_t beats[$];
  int    accs[$];

  // Handshake log, stamped with the edge number at which each transfer happened.
  always @(posedge clk) begin
    if (!rst) begin
      if (bf.d_valid && bf.d_ready) beats.push_back('{cyc, 1'b0, bf.d_data, 1'b0});
      if (bf.c_valid && bf.c_ready) beats.push_back('{cyc, 1'b1, {2'b00, bf.c_data}, bf.c_index});
      if (bf.in_valid && bf.in_ready) accs.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  function automatic eNestedSt mk(logic va, dSt b, seeSt j0, seeSt j1);
    eNestedSt r;
    r.variablea = va;
    r.bob       = b;
    r.joe[0]    = j0;
    r.joe[1]    = j1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bf.in_valid = 1'b0;
    bf.in_data  = '0;
    bf.d_ready  = 1'b1;
    bf.c_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Presents rec until accepted (bounded), then drops in_valid.
  task automatic send(eNestedSt rec);
    int n = 0;
    bf.in_data  = rec;
    bf.in_valid = 1'b1;
    #1;
    while (!bf.in_ready && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed %b, want 1", bf.in_ready);
    end
    step();
    bf.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bf.in_valid = 1'b0;
    bf.in_data  = mk(1'b1, 7'h7F, 5'h1F, 5'h1F);
    bf.d_ready  = 1'b0;
    bf.c_ready  = 1'b0;
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bf.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bf.in_ready); end
    checks++; if (bf.status !== READY_YES) begin errors++; $display("FAIL rst_status: got %b want 1", bf.status); end
    checks++; if ({bf.d_valid, bf.c_valid} !== 2'b00) begin errors++; $display("FAIL rst_valids: got %b want 00", {bf.d_valid, bf.c_valid}); end
    checks++; if ({bf.d_data, bf.c_data, bf.c_index} !== 13'h0) begin errors++; $display("FAIL rst_data: got %h want 0", {bf.d_data, bf.c_data, bf.c_index}); end
    checks++; if (bf.done_count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", bf.done_count); end
  endtask

  task automatic test_basic();
    int b0, a0, a;
    logic [8:0] exp [3];
    do_reset();
    b0 = beats.size(); a0 = accs.size();
    exp[0] = {1'b0, 7'h5A, 1'b0};
    exp[1] = {1'b1, 7'h03, 1'b0};
    exp[2] = {1'b1, 7'h1C, 1'b1};
    send(mk(1'b0, 7'h5A, 5'h03, 5'h1C));
    repeat (4) step();
    checks++; if (beats.size() - b0 !== 3) begin errors++; $display("FAIL basic_nbeats: got %0d want 3", beats.size() - b0); end
    a = accs[a0];
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({beats[b0+k].is_c, beats[b0+k].data, beats[b0+k].idx} !== exp[k] || beats[b0+k].cyc - a !== k + 1) begin
        errors++;
        $display("FAIL basic_beat%0d: got %h @+%0d want %h @+%0d", k,
                 {beats[b0+k].is_c, beats[b0+k].data, beats[b0+k].idx}, beats[b0+k].cyc - a, exp[k], k + 1);
      end
    end
    checks++; if (bf.done_count !== 8'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", bf.done_count); end
  endtask

  task automatic test_order();
    int b0;
    logic [8:0] exp [3];
    do_reset();
    b0 = beats.size();
    exp[0] = {1'b0, 7'h5A, 1'b0};
    exp[1] = {1'b1, 7'h1C, 1'b1};
    exp[2] = {1'b1, 7'h03, 1'b0};
    send(mk(1'b1, 7'h5A, 5'h03, 5'h1C));
    repeat (4) step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({beats[b0+k].is_c, beats[b0+k].data, beats[b0+k].idx} !== exp[k]) begin
        errors++;
        $display("FAIL order_beat%0d: got %h want %h", k, {beats[b0+k].is_c, beats[b0+k].data, beats[b0+k].idx}, exp[k]);
      end
    end
    checks++; if (bf.done_count !== 8'd1) begin errors++; $display("FAIL order_count: got %0d want 1", bf.done_count); end
  endtask

  task automatic test_backpressure();
    int b0, a0, a;
    do_reset();
    b0 = beats.size(); a0 = accs.size();
    bf.d_ready = 1'b0;
    send(mk(1'b0, 7'h5A, 5'h03, 5'h1C));
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({bf.d_valid, bf.c_valid, bf.d_data, bf.in_ready} !== {1'b1, 1'b0, 7'h5A, 1'b0}) begin
        errors++;
        $display("FAIL bp_d_hold%0d: got v=%b c=%b d=%h rdy=%b want v=1 c=0 d=5a rdy=0", k,
                 bf.d_valid, bf.c_valid, bf.d_data, bf.in_ready);
      end
      step();
    end
    bf.d_ready = 1'b1;
    step();
    checks++; if ({bf.c_valid, bf.c_data, bf.c_index} !== {1'b1, 5'h03, 1'b0}) begin errors++; $display("FAIL bp_c0: got %h want %h", {bf.c_valid, bf.c_data, bf.c_index}, {1'b1, 5'h03, 1'b0}); end
    step();
    bf.c_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bf.c_valid, bf.c_data, bf.c_index, bf.in_ready, bf.status, bf.done_count} !== {1'b1, 5'h1C, 1'b1, 1'b0, READY_NO, 8'd0}) begin
        errors++;
        $display("FAIL bp_c_hold%0d: got c=%b d=%h i=%b rdy=%b st=%b cnt=%0d want c=1 d=1c i=1 rdy=0 st=0 cnt=0", k,
                 bf.c_valid, bf.c_data, bf.c_index, bf.in_ready, bf.status, bf.done_count);
      end
      step();
    end
    bf.c_ready = 1'b1;
    #1;
    checks++; if ({bf.in_ready, bf.status} !== {1'b1, READY_YES}) begin errors++; $display("FAIL bp_c1_ready: got %b want 11", {bf.in_ready, bf.status}); end
    step();
    checks++; if (bf.done_count !== 8'd1) begin errors++; $display("FAIL bp_count: got %0d want 1", bf.done_count); end
    a = accs[a0];
    checks++;
    if (beats.size() - b0 !== 3 || beats[b0].cyc - a !== 5 || beats[b0+1].cyc - a !== 6 || beats[b0+2].cyc - a !== 10) begin
      errors++;
      $display("FAIL bp_timing: got n=%0d @+%0d,+%0d,+%0d want n=3 @+5,+6,+10", beats.size() - b0,
               beats[b0].cyc - a, beats[b0+1].cyc - a, beats[b0+2].cyc - a);
    end
  endtask

  task automatic test_back_to_back();
    int b0, a0, n;
    eNestedSt r;
    logic [8:0] exp;
    do_reset();
    b0 = beats.size(); a0 = accs.size();
    bf.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bf.in_data = mk(1'(k % 2), 7'(7'h10 + k), 5'(5'h01 + k), 5'(5'h11 + k));
      #1;
      n = 0;
      while (!bf.in_ready && n < 20) begin step(); n++; end
      step();
    end
    bf.in_valid = 1'b0;
    repeat (4) step();
    checks++; if (accs.size() - a0 !== 5) begin errors++; $display("FAIL b2b_naccs: got %0d want 5", accs.size() - a0); end
    for (int k = 1; k < 5; k++) begin
      checks++;
      if (accs[a0+k] - accs[a0+k-1] !== 3) begin errors++; $display("FAIL b2b_gap%0d: got %0d want 3", k, accs[a0+k] - accs[a0+k-1]); end
    end
    checks++; if (beats.size() - b0 !== 15) begin errors++; $display("FAIL b2b_nbeats: got %0d want 15", beats.size() - b0); end
    for (int j = 0; j < 15; j++) begin
      r = mk(1'((j / 3) % 2), 7'(7'h10 + j / 3), 5'(5'h01 + j / 3), 5'(5'h11 + j / 3));
      case (j % 3)
        0:       exp = {1'b0, r.bob, 1'b0};
        1:       exp = {1'b1, 2'b00, r.joe[r.variablea], r.variablea};
        default: exp = {1'b1, 2'b00, r.joe[~r.variablea], ~r.variablea};
      endcase
      checks++;
      if ({beats[b0+j].is_c, beats[b0+j].data, beats[b0+j].idx} !== exp || beats[b0+j].cyc - accs[a0] !== j + 1) begin
        errors++;
        $display("FAIL b2b_beat%0d: got %h @+%0d want %h @+%0d", j,
                 {beats[b0+j].is_c, beats[b0+j].data, beats[b0+j].idx}, beats[b0+j].cyc - accs[a0], exp, j + 1);
      end
    end
    checks++; if (bf.done_count !== 8'd5) begin errors++; $display("FAIL b2b_count: got %0d want 5", bf.done_count); end
  endtask

  task automatic test_reset_mid();
    int b1;
    do_reset();
    send(mk(1'b0, 7'h5A, 5'h03, 5'h1C));
    step();
    checks++; if ({bf.c_valid, bf.c_data} !== {1'b1, 5'h03}) begin errors++; $display("FAIL rmid_pre: got %h want %h", {bf.c_valid, bf.c_data}, {1'b1, 5'h03}); end
    rst = 1'b1;
    #1;
    checks++;
    if ({bf.in_ready, bf.status, bf.d_valid, bf.c_valid, bf.d_data, bf.c_data, bf.c_index, bf.done_count} !== {1'b1, READY_YES, 15'h0, 8'd0}) begin
      errors++;
      $display("FAIL rmid_outs: got rdy=%b st=%b dv=%b cv=%b d=%h c=%h i=%b cnt=%0d want 1 1 0 0 0 0 0 0",
               bf.in_ready, bf.status, bf.d_valid, bf.c_valid, bf.d_data, bf.c_data, bf.c_index, bf.done_count);
    end
    b1 = beats.size();
    repeat (2) step();
    rst = 1'b0;
    repeat (4) step();
    checks++; if (beats.size() !== b1 || bf.c_valid !== 1'b0) begin errors++; $display("FAIL rmid_nobeat: got %0d beats cv=%b want 0 beats cv=0", beats.size() - b1, bf.c_valid); end
    checks++; if (bf.done_count !== 8'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", bf.done_count); end
    send(mk(1'b1, 7'h2A, 5'h05, 5'h0A));
    repeat (4) step();
    checks++;
    if (beats.size() - b1 !== 3 || {beats[b1+1].data, beats[b1+1].idx, beats[b1+2].data, beats[b1+2].idx} !== {7'h0A, 1'b1, 7'h05, 1'b0}) begin
      errors++;
      $display("FAIL rmid_next: got n=%0d c=%h/%b,%h/%b want n=3 c=0a/1,05/0", beats.size() - b1,
               beats[b1+1].data, beats[b1+1].idx, beats[b1+2].data, beats[b1+2].idx);
    end
    checks++; if (bf.done_count !== 8'd1) begin errors++; $display("FAIL rmid_count2: got %0d want 1", bf.done_count); end
  endtask

  task automatic test_wrap();
    logic [1:0] expw [5];
    expw = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send(mk(1'(k % 2), 7'(7'h40 + k), 5'(k), 5'(5'h10 + k)));
      repeat (3) step();
      checks++;
      if (bw.done_count !== expw[k] || bf.done_count !== 8'(k + 1)) begin
        errors++;
        $display("FAIL wrap%0d: got w=%0d n=%0d want w=%0d n=%0d", k, bw.done_count, bf.done_count, expw[k], k + 1);
      end
    end
  endtask

  initial begin
    bf.in_valid = 1'b0;
    bf.in_data  = '0;
    bf.d_ready  = 1'b1;
    bf.c_ready  = 1'b1;
    test_reset();
    test_basic();
    test_order();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
